// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Multicycle MIPS control unit. Steps each instruction through
//   FETCH/DECODE/EXEC/MEM/WB, using the ihit/dhit handshakes from the memory
//   arbiter. It owns the instruction register, the per-state strobes, the
//   sticky halt/fault flags and a watchdog on memory waits.
//
//   Parameters
//     TIMEOUT  - wait cycles allowed for ihit/dhit before faulting (0 = off)
//     OVF_TRAP - 1: signed overflow on ADD/SUB/ADDI faults, no writeback
//     HALT_OP  - opcode that halts the core cleanly
//
//   Ports
//     CLK, nRST            clock, asynchronous active-low reset
//     imemload, ihit       fetched instruction and its completion
//     dhit                 data access completion
//     vflag, zero          ALU overflow / zero flags, sampled in EXEC
//     ir                   latched instruction register
//     iren, dren, dwen     memory request strobes
//     pc_en, pc_src        PC load strobe and source (0 +4, 1 br, 2 j, 3 jr)
//     regwrite, regdst     register-file write strobe, dest (0 rt, 1 rd, 2 $31)
//     memtoreg, alusrc,
//     extend, lui, aluop   static decode fields derived from ir
//     halt, fault          sticky halt and abnormal-halt flags
//     state                current FSM state for debug

package cpu_types_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'h00, J     = 6'h02, JAL   = 6'h03, BEQ  = 6'h04,
        BNE   = 6'h05, ADDI  = 6'h08, ADDIU = 6'h09, SLTI = 6'h0A,
        SLTIU = 6'h0B, ANDI  = 6'h0C, ORI   = 6'h0D, XORI = 6'h0E,
        LUI   = 6'h0F, LW    = 6'h23, SW    = 6'h2B, HALT = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        SLL  = 6'h00, SRL = 6'h02, JR  = 6'h08, ADD  = 6'h20,
        ADDU = 6'h21, SUB = 6'h22, SUBU = 6'h23, AND = 6'h24,
        OR   = 6'h25, XOR = 6'h26, NOR = 6'h27, SLT  = 6'h2A,
        SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB  = 4'd3,
        ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR  = 4'd7,
        ALU_SLT = 4'd8, ALU_SLTU = 4'd9
    } aluop_t;

endpackage

module multicycle_control_fsm
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter bit          OVF_TRAP = 1'b1,
    parameter logic [5:0]  HALT_OP  = 6'h3F
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] imemload,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        vflag,
    input  logic        zero,
    output logic [31:0] ir,
    output logic        iren,
    output logic        dren,
    output logic        dwen,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        regwrite,
    output logic [1:0]  regdst,
    output logic        memtoreg,
    output logic        alusrc,
    output logic        extend,
    output logic        lui,
    output logic [3:0]  aluop,
    output logic        halt,
    output logic        fault,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WLIM = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    state_t        cur_state, next_state;
    logic [CW-1:0] wcnt;
    logic [5:0]    op, fn;
    logic          op_valid, fn_valid, is_rtype, trap_op, wd_expire;
    logic          ir_load, set_fault, wcnt_inc;
    logic          iren_c, dren_c, dwen_c, pc_en_c, regwrite_c;
    aluop_t        aluop_c;

    assign op       = ir[31:26];
    assign fn       = ir[5:0];
    assign is_rtype = (op == RTYPE);
    assign trap_op  = (is_rtype && (fn == ADD || fn == SUB)) || (op == ADDI);
    // Expires on the wait cycle that would make the count reach TIMEOUT; the
    // hit checks come first in the FSM so a hit in that same cycle wins.
    assign wd_expire = (TIMEOUT != 0) && (wcnt == WLIM);

    // Static decode, valid whenever ir holds the current instruction.
    always_comb begin
        op_valid = 1'b1;
        fn_valid = 1'b1;
        aluop_c  = ALU_ADD;
        alusrc   = 1'b0;
        extend   = 1'b0;
        lui      = 1'b0;
        regdst   = 2'd0;
        memtoreg = 1'b0;
        case (op)
            RTYPE: begin
                regdst = 2'd1;
                case (fn)
                    SLL:        aluop_c = ALU_SLL;
                    SRL:        aluop_c = ALU_SRL;
                    JR:         aluop_c = ALU_ADD;
                    ADD, ADDU:  aluop_c = ALU_ADD;
                    SUB, SUBU:  aluop_c = ALU_SUB;
                    AND:        aluop_c = ALU_AND;
                    OR:         aluop_c = ALU_OR;
                    XOR:        aluop_c = ALU_XOR;
                    NOR:        aluop_c = ALU_NOR;
                    SLT:        aluop_c = ALU_SLT;
                    SLTU:       aluop_c = ALU_SLTU;
                    default:    fn_valid = 1'b0;
                endcase
            end
            J:     aluop_c = ALU_ADD;
            JAL:   regdst  = 2'd2;
            BEQ, BNE: begin
                aluop_c = ALU_SUB;
                extend  = 1'b1;
            end
            ADDI, ADDIU: begin
                alusrc = 1'b1;
                extend = 1'b1;
            end
            SLTI: begin
                aluop_c = ALU_SLT;
                alusrc  = 1'b1;
                extend  = 1'b1;
            end
            SLTIU: begin
                aluop_c = ALU_SLTU;
                alusrc  = 1'b1;
                extend  = 1'b1;
            end
            ANDI: begin
                aluop_c = ALU_AND;
                alusrc  = 1'b1;
            end
            ORI: begin
                aluop_c = ALU_OR;
                alusrc  = 1'b1;
            end
            XORI: begin
                aluop_c = ALU_XOR;
                alusrc  = 1'b1;
            end
            LUI: begin
                alusrc = 1'b1;
                lui    = 1'b1;
            end
            LW: begin
                alusrc   = 1'b1;
                extend   = 1'b1;
                memtoreg = 1'b1;
            end
            SW: begin
                alusrc = 1'b1;
                extend = 1'b1;
            end
            default: op_valid = 1'b0;
        endcase
    end

    assign aluop = aluop_c;

    always_comb begin
        next_state = cur_state;
        iren_c     = 1'b0;
        dren_c     = 1'b0;
        dwen_c     = 1'b0;
        pc_en_c    = 1'b0;
        pc_src     = 2'd0;
        regwrite_c = 1'b0;
        ir_load    = 1'b0;
        set_fault  = 1'b0;
        wcnt_inc   = 1'b0;
        case (cur_state)
            S_FETCH: begin
                iren_c = 1'b1;
                if (ihit) begin
                    ir_load    = 1'b1;
                    pc_en_c    = 1'b1;
                    next_state = S_DECODE;
                end else if (wd_expire) begin
                    set_fault  = 1'b1;
                    next_state = S_HALT;
                end else begin
                    wcnt_inc = 1'b1;
                end
            end
            S_DECODE: begin
                if (op == HALT_OP) begin
                    next_state = S_HALT;
                end else if (!op_valid || (is_rtype && !fn_valid)) begin
                    set_fault  = 1'b1;
                    next_state = S_HALT;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (OVF_TRAP && vflag && trap_op) begin
                    set_fault  = 1'b1;
                    next_state = S_HALT;
                end else if (op == BEQ || op == BNE) begin
                    if ((op == BEQ) == zero) begin
                        pc_en_c = 1'b1;
                        pc_src  = 2'd1;
                    end
                    next_state = S_FETCH;
                end else if (op == J) begin
                    pc_en_c    = 1'b1;
                    pc_src     = 2'd2;
                    next_state = S_FETCH;
                end else if (is_rtype && fn == JR) begin
                    pc_en_c    = 1'b1;
                    pc_src     = 2'd3;
                    next_state = S_FETCH;
                end else if (op == JAL) begin
                    pc_en_c    = 1'b1;
                    pc_src     = 2'd2;
                    next_state = S_WB;
                end else if (op == LW || op == SW) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                // Only LW and SW reach MEM, so the two requests are exclusive.
                if (op == LW) dren_c = 1'b1;
                else          dwen_c = 1'b1;
                if (dhit) begin
                    next_state = (op == LW) ? S_WB : S_FETCH;
                end else if (wd_expire) begin
                    set_fault  = 1'b1;
                    next_state = S_HALT;
                end else begin
                    wcnt_inc = 1'b1;
                end
            end
            S_WB: begin
                regwrite_c = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cur_state <= S_FETCH;
            ir        <= '0;
            halt      <= 1'b0;
            fault     <= 1'b0;
            wcnt      <= '0;
        end else begin
            cur_state <= next_state;
            if (ir_load)              ir    <= imemload;
            if (next_state == S_HALT) halt  <= 1'b1;
            if (set_fault)            fault <= 1'b1;
            wcnt <= wcnt_inc ? wcnt + 1'b1 : '0;
        end
    end

    // Strobes are gated by nRST so requests drop the moment reset asserts,
    // even though the reset state (FETCH) would otherwise request a fetch.
    assign iren     = iren_c     & nRST;
    assign dren     = dren_c     & nRST;
    assign dwen     = dwen_c     & nRST;
    assign pc_en    = pc_en_c    & nRST;
    assign regwrite = regwrite_c & nRST;
    assign state    = cur_state;

endmodule
